// File: rtl/red_pitaya_scope_decim_if.sv
// Sample-stream interface between the ADC equalizer, the decimator and the
// scope capture buffer. Signal names carry the decimator's own _i/_o view.
// Handshake: there is no ready; adc_dat_i is valid every cycle and
// dec_dat_o is new exactly on cycles where dec_dv_o is high.
interface red_pitaya_scope_decim_if #(
    parameter int DW = 14
) ();
    logic signed [DW-1:0] adc_dat_i;
    logic        [4:0]    cfg_dec_exp_i;
    logic                 sync_i;
    logic signed [DW-1:0] dec_dat_o;
    logic                 dec_dv_o;

    // Producer side: drives samples, configuration and sync.
    modport master (
        output adc_dat_i,
        output cfg_dec_exp_i,
        output sync_i,
        input  dec_dat_o,
        input  dec_dv_o
    );

    // Decimator side.
    modport slave (
        input  adc_dat_i,
        input  cfg_dec_exp_i,
        input  sync_i,
        output dec_dat_o,
        output dec_dv_o
    );
endinterface

// File: rtl/red_pitaya_scope_decim.sv
// Decimating averager for the oscilloscope path. Sums non-overlapping
// windows of 2^N samples and emits one averaged (floor) sample per window
// with a single-cycle valid strobe. sync_i or an exponent change restarts
// the window phase and discards the sample of that cycle.
// Build option: define SCOPE_DECIM_AVG_EN for averaging; without it the
// block subsamples (outputs the last sample of each window) and the
// accumulator is not built. Window timing is identical in both builds.
module red_pitaya_scope_decim #(
    parameter int DW      = 14,
    parameter int EXP_MAX = 16
) (
    input  logic                   adc_clk_i,
    input  logic                   adc_rst_i,
    red_pitaya_scope_decim_if.slave dec_if
);

    localparam int AW = DW + EXP_MAX;

    logic        [4:0]         cfg_exp_q, cfg_exp_d;
    logic        [EXP_MAX-1:0] cnt_q, cnt_d;
    logic signed [DW-1:0]      dat_q, dat_d;
    logic                      dv_q, dv_d;

    logic        [4:0]         ne;
    logic        [EXP_MAX-1:0] cnt_last;
    logic                      restart;
    logic                      win_end;
    logic signed [DW-1:0]      win_dat;

    // Effective exponent: anything above EXP_MAX behaves as EXP_MAX.
    always_comb begin
        if (cfg_exp_q > 5'(EXP_MAX)) begin
            ne = 5'(EXP_MAX);
        end else begin
            ne = cfg_exp_q;
        end
    end

    // Last window position 2^ne - 1, built as a mask of ne low ones.
    always_comb begin
        cnt_last = '0;
        for (int i = 0; i < EXP_MAX; i++) begin
            if (i < int'(ne)) begin
                cnt_last[i] = 1'b1;
            end
        end
    end

    // Restart beats window end: a sync or a new exponent drops the window.
    always_comb begin
        restart = dec_if.sync_i | (dec_if.cfg_dec_exp_i != cfg_exp_q);
        win_end = !restart && (cnt_q == cnt_last);
    end

`ifdef SCOPE_DECIM_AVG_EN
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sum;

    // Running sum including the current sample; the floor-average is the
    // arithmetic shift of that sum (it always fits back into DW bits).
    always_comb begin
        sum     = acc_q + {{EXP_MAX{dec_if.adc_dat_i[DW-1]}}, dec_if.adc_dat_i};
        win_dat = DW'(sum >>> ne);
    end

    // Accumulator next state: clear on restart or window end, else add.
    always_comb begin
        acc_d = sum;
        if (restart || win_end) begin
            acc_d = '0;
        end
    end

    // Accumulator register.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // Subsampling: the window result is simply its last sample.
    always_comb begin
        win_dat = dec_if.adc_dat_i;
    end
`endif

    // Window counter, exponent latch and output next state.
    always_comb begin
        cfg_exp_d = cfg_exp_q;
        cnt_d     = cnt_q + EXP_MAX'(1);
        dat_d     = dat_q;
        dv_d      = 1'b0;
        if (restart) begin
            cfg_exp_d = dec_if.cfg_dec_exp_i;
            cnt_d     = '0;
        end else if (win_end) begin
            cnt_d = '0;
            dat_d = win_dat;
            dv_d  = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            cfg_exp_q <= '0;
            cnt_q     <= '0;
            dat_q     <= '0;
            dv_q      <= 1'b0;
        end else begin
            cfg_exp_q <= cfg_exp_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            dv_q      <= dv_d;
        end
    end

    assign dec_if.dec_dat_o = dat_q;
    assign dec_if.dec_dv_o  = dv_q;

endmodule

// File: tb/tb_red_pitaya_scope_decim.sv
// Bench for red_pitaya_scope_decim: directed vectors, a window-queue model
// checked every cycle, and literal expectations at key points.
// Honours SCOPE_DECIM_AVG_EN the same way the design does.
module tb_red_pitaya_scope_decim;
    localparam int DW = 14;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    red_pitaya_scope_decim_if #(.DW(DW)) bus ();

    red_pitaya_scope_decim #(.DW(DW), .EXP_MAX(16)) dut (
        .adc_clk_i (clk),
        .adc_rst_i (rst),
        .dec_if    (bus.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs presented at the next rising edge; returns #1 after that edge.
    task automatic step(input int d, input int cfg, input bit s);
        bus.adc_dat_i     = DW'(d);
        bus.cfg_dec_exp_i = 5'(cfg);
        bus.sync_i        = s;
        @(posedge clk);
        #1;
    endtask

`ifdef SCOPE_DECIM_AVG_EN
    function automatic int floor_div(input longint s, input longint d);
        if (s >= 0) return int'(s / d);
        return int'(-((-s + d - 1) / d));
    endfunction
`endif

    // Model: collect the samples of the current window in a queue; when the
    // queue holds 2^Ne samples the window result is produced.
    int   m_exp_r;
    int   m_win[$];
    logic m_dv;
    int   m_dat;
    bit   m_live;
    always @(posedge clk) begin
        int     ne;
        longint s;
        if (rst) begin
            m_exp_r = 0;
            m_win.delete();
            m_dv    = 1'b0;
            m_dat   = 0;
        end else if (bus.sync_i || int'(bus.cfg_dec_exp_i) != m_exp_r) begin
            m_exp_r = int'(bus.cfg_dec_exp_i);
            m_win.delete();
            m_dv    = 1'b0;
        end else begin
            m_win.push_back(int'(bus.adc_dat_i));
            ne = (m_exp_r > 16) ? 16 : m_exp_r;
            if (m_win.size() == (1 << ne)) begin
`ifdef SCOPE_DECIM_AVG_EN
                s = 0;
                foreach (m_win[k]) s += m_win[k];
                m_dat = floor_div(s, longint'(1) << ne);
`else
                m_dat = m_win[m_win.size() - 1];
`endif
                m_dv = 1'b1;
                m_win.delete();
            end else begin
                m_dv = 1'b0;
            end
        end
        m_live = 1'b1;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("model_dv", bus.dec_dv_o, m_dv);
            check("model_dat", bus.dec_dat_o, m_dat);
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        int pulses;
        int first;
        int vals[4];
        errors = 0;
        checks = 0;
        m_live = 1'b0;
        rst    = 1'b1;
        bus.adc_dat_i     = '0;
        bus.cfg_dec_exp_i = '0;
        bus.sync_i        = 1'b0;

        // reset state
        step(0, 0, 0);
        step(0, 0, 0);
        check("reset_dat", bus.dec_dat_o, 0);
        check("reset_dv", bus.dec_dv_o, 0);
        rst = 1'b0;

        // constant 100, N=3: first post-reset cycle is a restart
        step(0, 3, 0);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 80; i++) begin
            step(100, 3, 0);
            if (bus.dec_dv_o === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
                check("const_dat", bus.dec_dat_o, 100);
            end
        end
        check("const_pulses", pulses, 10);
        check("const_first", first, 8);

        // ramp 0..7 after sync
        step(0, 3, 1);
        for (int i = 0; i < 8; i++) begin
            step(i, 3, 0);
            if (i == 6) check("ramp_dv_early", bus.dec_dv_o, 0);
        end
        check("ramp_dv", bus.dec_dv_o, 1);
`ifdef SCOPE_DECIM_AVG_EN
        check("ramp_dat", bus.dec_dat_o, 3);
`else
        check("ramp_dat", bus.dec_dat_o, 7);
`endif

        // -1, -2 with N=1: floor average and last sample both give -2
        step(0, 1, 0);
        step(-1, 1, 0);
        step(-2, 1, 0);
        check("neg_dv", bus.dec_dv_o, 1);
        check("neg_dat", bus.dec_dat_o, -2);

        // sync at window position 5: next pulse 9 cycles after sync cycle
        step(0, 3, 0);
        for (int i = 0; i < 5; i++) step(10 + i, 3, 0);
        step(99, 3, 1);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(20, 3, 0);
            if (bus.dec_dv_o === 1'b1 && first == 0) first = k;
        end
        check("sync_mid_gap", first, 8);
        check("sync_mid_dat", bus.dec_dat_o, 20);

        // sync on a window-end cycle suppresses that output
        for (int i = 0; i < 7; i++) step(30, 3, 0);
        step(30, 3, 1);
        check("sync_end_dv", bus.dec_dv_o, 0);
        check("sync_end_dat", bus.dec_dat_o, 20);

        // exponent change 3 -> 2 mid-window, then 4-cycle spacing
        for (int i = 0; i < 3; i++) step(40, 3, 0);
        step(40, 2, 0);
        check("cfg_chg_dv", bus.dec_dv_o, 0);
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= 8; k++) begin
            step(44, 2, 0);
            if (bus.dec_dv_o === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check("cfg_chg_pulses", pulses, 2);
        check("cfg_chg_first", first, 4);
        check("cfg_chg_dat", bus.dec_dat_o, 44);

        // N=0: output follows input one cycle later, valid held high
        step(0, 0, 0);
        check("n0_restart_dv", bus.dec_dv_o, 0);
        vals[0] = 5; vals[1] = -7; vals[2] = 123; vals[3] = -8192;
        for (int i = 0; i < 4; i++) begin
            step(vals[i], 0, 0);
            check("n0_dv", bus.dec_dv_o, 1);
            check("n0_dat", bus.dec_dat_o, vals[i]);
        end

        // reset mid-window discards the partial sum
        step(0, 3, 0);
        for (int i = 0; i < 4; i++) step(500, 3, 0);
        rst = 1'b1;
        step(500, 3, 0);
        check("midrst_dat", bus.dec_dat_o, 0);
        check("midrst_dv", bus.dec_dv_o, 0);
        rst = 1'b0;
        step(0, 3, 0);
        for (int i = 0; i < 8; i++) step(-3, 3, 0);
        check("midrst_next_dv", bus.dec_dv_o, 1);
        check("midrst_next_dat", bus.dec_dat_o, -3);

        // positive full scale, N=10
        step(0, 10, 0);
        for (int i = 0; i < 1024; i++) step(8191, 10, 0);
        check("max_dv", bus.dec_dv_o, 1);
        check("max_dat", bus.dec_dat_o, 8191);

        // negative full scale with exponent 20 (behaves as 16)
        step(0, 20, 0);
        for (int i = 0; i < 65535; i++) step(-8192, 20, 0);
        check("n16_dv_early", bus.dec_dv_o, 0);
        step(-8192, 20, 0);
        check("n16_dv", bus.dec_dv_o, 1);
        check("n16_dat", bus.dec_dat_o, -8192);
        step(0, 20, 0);
        check("n16_dv_after", bus.dec_dv_o, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/red_pitaya_scope_decim.md
# red_pitaya_scope_decim

Decimating averager that sits directly downstream of the ADC equalization filter and feeds the oscilloscope capture buffer. It takes the filter's 14-bit signed sample stream, one sample per `adc_clk_i` cycle, and sums non-overlapping windows of 2^N samples. Each completed window produces one averaged 14-bit output sample and a single-cycle valid strobe. A sync input restarts the decimation phase so captured data can be phase-aligned to an arm or trigger event.

## Interface
Parameters:
- `DW`, 14: sample width, signed two's complement.
- `EXP_MAX`, 16: largest supported decimation exponent (window of 65536 samples).

Ports:
- `adc_clk_i`, input, 1: ADC clock; the only clock.
- `adc_rst_i`, input, 1: reset; synchronous, active-high.
- `adc_dat_i`, input, DW: equalized sample; valid on every cycle.
- `cfg_dec_exp_i`, input, 5: decimation exponent N; window = 2^N samples.
- `sync_i`, input, 1: phase restart strobe.
- `dec_dat_o`, output, DW: decimated sample, signed.
- `dec_dv_o`, output, 1: one-cycle pulse; `dec_dat_o` is new on that cycle.

## Operation
- Internal state:
  - `cfg_exp_r` (5 bit): registered exponent.
  - `cnt` (EXP_MAX bit): window position.
  - `acc` (DW+EXP_MAX = 30 bit, signed): window sum.
- Effective exponent `Ne` = min(`cfg_exp_r`, EXP_MAX). Values 17..31 behave as 16.
- Each cycle outside restart:
  - The input is added to `acc`.
  - `cnt` increments.
- Window end occurs when `cnt` == 2^Ne − 1:
  - `dec_dat_o` <= (`acc` + `adc_dat_i`) >>> Ne. This is an arithmetic shift, i.e. floor.
  - `dec_dv_o` <= 1.
  - `acc` <= 0 and `cnt` <= 0.
- In all other cycles `dec_dv_o` <= 0 and `dec_dat_o` holds its value.
- Arithmetic: `acc` cannot overflow; the worst case is 65536 × −8192 = −2^29. The shifted result always fits in DW bits, so no saturation logic is present.
- Restart condition: `sync_i` == 1, or `cfg_dec_exp_i` != `cfg_exp_r`. On restart:
  - `acc` <= 0, `cnt` <= 0, `cfg_exp_r` <= `cfg_dec_exp_i`, `dec_dv_o` <= 0.
  - The sample presented in the restart cycle is discarded.
  - The next cycle's sample is sample 0 of a new window.
- Restart coinciding with window end: restart wins. No output is produced and the partial sum is discarded.
- Ne = 0: every cycle is a window end. `dec_dat_o` = `adc_dat_i` delayed by one cycle, and `dec_dv_o` stays high continuously except during restart cycles.

## Timing
- Reset (`adc_rst_i` high at a clock edge):
  - `dec_dat_o` = 0, `dec_dv_o` = 0, `acc` = 0, `cnt` = 0.
  - `cfg_exp_r` = 0. The first post-reset cycle with a non-zero `cfg_dec_exp_i` is therefore a restart cycle.
- Reset applied mid-window discards the partial window, and no output is emitted.
- Latency: `dec_dv_o` is high in the cycle after the last sample of a window is presented.
- Throughput: exactly one output pulse per 2^Ne input cycles in steady state.
- After a restart in cycle t, the first `dec_dv_o` occurs in cycle t + 2^Ne + 1.
- `dec_dat_o` is stable between pulses. The capture buffer may sample it on any cycle where `dec_dv_o` is high.
- There is no backpressure; the consumer must accept every pulse.

## Configuration
- Macro `SCOPE_DECIM_AVG_EN`.
- Defined: averaging as described under Operation.
- Undefined (plain subsampling):
  - `acc` and the adder are not built.
  - At window end, `dec_dat_o` <= `adc_dat_i`, i.e. the last sample of the window.
  - Counter, restart rules, latency and `dec_dv_o` timing are identical to the averaging build.

## Test plan
- Constant input 100 with N = 3, held for 80 cycles after a restart: 10 pulses spaced 8 cycles apart, each with `dec_dat_o` = 100. In the subsampling build the output is also 100.
- Ramp input 0..7 with N = 3 → `dec_dat_o` = 3 (sum 28 >> 3). Inputs −1, −2 with N = 1 → `dec_dat_o` = −2 (floor). Subsampling build: outputs 7 and −2.
- Input −8192 held with N = 16 → one pulse after 65537 cycles with `dec_dat_o` = −8192. Input 8191 held with N = 16 → 8191. Setting `cfg_dec_exp_i` = 20 must give the identical 65536-sample period.
- N = 3: pulse `sync_i` at window position 5 → no pulse for that window, and the next pulse arrives exactly 9 cycles after the sync cycle. Pulse `sync_i` on a window-end cycle → that output is suppressed.
- Change `cfg_dec_exp_i` from 3 to 2 mid-window → restart behaviour as above, with 4-cycle spacing afterwards. With N = 0, `dec_dat_o` tracks the input with a 1-cycle delay and `dec_dv_o` is held high.
- Assert `adc_rst_i` for 1 cycle mid-window → `dec_dat_o` = 0 and `dec_dv_o` = 0 the next cycle, and no stale partial sum appears in the following output.
